aes_block_loader: RTL and testbench

//  Upstream feeder for the 128-bit state/key register stage. Packs a stream of
//  32-bit words from the host interface into one 128-bit AES block. Presents the

---
 rtl/aes_pkg.sv | 14 +
 rtl/aes_block_loader.sv | 96 +++++++++
 tb/tb_aes_block_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES widths and types for the block-loader front end.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_WORD_W  = 32;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic {
        LD_FILL,
        LD_HOLD
    } loader_state_e;

endpackage

// File: rtl/aes_block_loader.sv
// Packs host words into one AES block and hands it to the register stage
// with a one-cycle load strobe, backpressuring the host while a block waits.
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W    = AES_WORD_W,
    parameter int unsigned BLOCK_W   = AES_BLOCK_W,
    parameter bit          MSW_FIRST = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               core_ready,
    output logic [BLOCK_W-1:0] buff_in,
    output logic               buff_en,
    output logic [1:0]         word_cnt,
    output logic [CNT_W-1:0]   blocks_loaded
);

    localparam int unsigned WORDS = BLOCK_W / WORD_W;

    // word_cnt is two bits wide, so the block must split into exactly four words
    if ((BLOCK_W % WORD_W) != 0 || WORDS != 4) begin : g_bad_geometry
        $error("aes_block_loader: BLOCK_W must be exactly 4 * WORD_W");
    end

    loader_state_e state_q;
    loader_state_e state_d;
    logic          armed_q;
    logic          accept_c;
    logic [1:0]    slot_c;

    // Next state and handshake outputs
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        in_ready = 1'b0;
        buff_en  = 1'b0;
        unique case (state_q)
            LD_FILL: begin
                in_ready = armed_q;
                accept_c = in_valid && armed_q && !clear;
                if (accept_c && word_cnt == 2'(WORDS - 1)) begin
                    state_d = LD_HOLD;
                end
            end
            LD_HOLD: begin
                buff_en = core_ready && !clear;
                if (buff_en) begin
                    state_d = LD_FILL;
                end
            end
            default: state_d = LD_FILL;
        endcase
        if (clear) begin
            state_d = LD_FILL;
        end
    end

    // Slot 0 lands in the top word when MSW_FIRST, else in the bottom word
    assign slot_c = MSW_FIRST ? (2'(WORDS - 1) - word_cnt) : word_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LD_FILL;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
        end
    end

    // Slot demux, fill counter and strobe counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buff_in       <= '0;
            word_cnt      <= 2'd0;
            blocks_loaded <= '0;
        end else begin
            if (clear) begin
                word_cnt <= 2'd0;
            end else if (accept_c) begin
                buff_in[32'(slot_c) * WORD_W +: WORD_W] <= in_data;
                word_cnt <= word_cnt + 2'd1;
            end
            if (buff_en) begin
                blocks_loaded <= blocks_loaded + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: an MSW-first/16-bit-counter instance and an
// LSW-first/4-bit-counter instance share stimulus and a word-level model.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         clear;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         core_ready;

    logic         a_in_ready, a_buff_en;
    logic [127:0] a_buff_in;
    logic [1:0]   a_word_cnt;
    logic [15:0]  a_blocks;

    logic         b_in_ready, b_buff_en;
    logic [127:0] b_buff_in;
    logic [1:0]   b_word_cnt;
    logic [3:0]   b_blocks;

    int n_pass  = 0;
    int n_total = 0;

    // Model: words held so far, block-waiting flag, loads issued
    logic [31:0] m_slot [4];
    int          m_n;
    bit          m_full;
    bit          m_armed;
    int          m_loads;

    always #5 clk = ~clk;

    aes_block_loader #(.WORD_W(32), .BLOCK_W(128), .MSW_FIRST(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .core_ready(core_ready), .buff_in(a_buff_in),
        .buff_en(a_buff_en), .word_cnt(a_word_cnt), .blocks_loaded(a_blocks)
    );

    aes_block_loader #(.WORD_W(32), .BLOCK_W(128), .MSW_FIRST(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .clear(clear), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .core_ready(core_ready), .buff_in(b_buff_in),
        .buff_en(b_buff_en), .word_cnt(b_word_cnt), .blocks_loaded(b_blocks)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [127:0] pack(input bit msw_first);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (msw_first) r[127 - 32*i -: 32] = m_slot[i];
            else           r[32*i +: 32]       = m_slot[i];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_n = 0; m_full = 0; m_armed = 0; m_loads = 0;
    endtask

    // Expected outputs for the current (stable) inputs
    task automatic check_all();
        logic exp_rdy, exp_en;
        exp_rdy = m_armed && !m_full;
        exp_en  = m_full && core_ready && !clear && reset;
        check("a_in_ready", 128'(a_in_ready), 128'(exp_rdy));
        check("b_in_ready", 128'(b_in_ready), 128'(exp_rdy));
        check("a_buff_en",  128'(a_buff_en),  128'(exp_en));
        check("b_buff_en",  128'(b_buff_en),  128'(exp_en));
        check("a_word_cnt", 128'(a_word_cnt), 128'(m_n));
        check("b_word_cnt", 128'(b_word_cnt), 128'(m_n));
        check("a_buff_in",  a_buff_in, pack(1'b1));
        check("b_buff_in",  b_buff_in, pack(1'b0));
        check("a_blocks",   128'(a_blocks), 128'(m_loads % 65536));
        check("b_blocks",   128'(b_blocks), 128'(m_loads % 16));
    endtask

    // Apply the effect of one rising edge to the model
    task automatic model_step();
        if (!reset) begin
            model_reset();
        end else begin
            if (clear) begin
                m_n = 0; m_full = 0;
            end else if (m_full) begin
                if (core_ready) begin m_full = 0; m_loads++; end
            end else if (m_armed && in_valid) begin
                m_slot[m_n] = in_data;
                m_n++;
                if (m_n == 4) begin m_n = 0; m_full = 1; end
            end
            m_armed = 1;
        end
    endtask

    task automatic half_a(); @(negedge clk); check_all(); endtask
    task automatic half_b(); model_step(); @(posedge clk); #1; endtask
    task automatic cycle();  half_a(); half_b(); endtask

    task automatic feed(input logic [31:0] w);
        in_valid = 1'b1; in_data = w; cycle();
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; core_ready = 1'b0;
        model_reset();
        cycle(); cycle();
        reset = 1'b1;
        cycle();

        // Back-to-back fill, core ready
        core_ready = 1'b1;
        feed(32'h00112233); feed(32'h44556677); feed(32'h8899aabb); feed(32'hccddeeff);
        in_valid = 1'b0;
        half_a();
        check("t1_strobe", 128'(a_buff_en), 128'(1));
        check("t1_a_blk", a_buff_in, 128'h00112233_44556677_8899aabb_ccddeeff);
        check("t1_b_blk", b_buff_in, 128'hccddeeff_8899aabb_44556677_00112233);
        half_b();
        half_a();
        check("t1_once", 128'(a_buff_en), 128'(0));
        check("t1_count", 128'(a_blocks), 128'(1));
        half_b();

        // Core stalls with a fifth word pending
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed($urandom);
        for (int i = 0; i < 10; i++) feed(32'hdeadbeef);
        core_ready = 1'b1;
        cycle();
        core_ready = 1'b0;
        cycle();
        half_a();
        check("t2_a_slot0", 128'(a_buff_in[127:96]), 128'(32'hdeadbeef));
        check("t2_b_slot0", 128'(b_buff_in[31:0]),   128'(32'hdeadbeef));
        half_b();
        for (int i = 0; i < 3; i++) feed($urandom);
        in_valid = 1'b0; core_ready = 1'b1;
        cycle(); cycle();

        // Partial fill flushed by clear
        feed(32'h11111111); feed(32'h22222222);
        in_valid = 1'b0; clear = 1'b1;
        cycle();
        clear = 1'b0;
        feed(32'ha0a0a0a0); feed(32'hb1b1b1b1); feed(32'hc2c2c2c2); feed(32'hd3d3d3d3);
        in_valid = 1'b0;
        half_a();
        check("t3_a_blk", a_buff_in, 128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3);
        half_b();

        // Clear beats core_ready in HOLD
        core_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed($urandom);
        in_valid = 1'b0; core_ready = 1'b1; clear = 1'b1;
        half_a();
        check("t4_no_strobe", 128'(a_buff_en), 128'(0));
        half_b();
        clear = 1'b0; core_ready = 1'b0;
        cycle(); cycle();

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) feed($urandom);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t5_a_rdy", 128'(a_in_ready), 128'(0));
        check("t5_a_cnt", 128'(a_word_cnt), 128'(0));
        check("t5_a_blk", a_buff_in, 128'(0));
        check("t5_a_loads", 128'(a_blocks), 128'(0));
        check("t5_b_blk", b_buff_in, 128'(0));
        model_reset();
        cycle();
        reset = 1'b1;
        cycle();
        core_ready = 1'b1;
        feed(32'h00112233); feed(32'h44556677); feed(32'h8899aabb); feed(32'hccddeeff);
        in_valid = 1'b0;
        half_a();
        check("t5_refill", 128'(a_buff_en), 128'(1));
        check("t5_b_blk2", b_buff_in, 128'hccddeeff_8899aabb_44556677_00112233);
        half_b();

        // Randomised traffic; the 4-bit counter wraps many times
        for (int i = 0; i < 800; i++) begin
            in_valid   = ($urandom_range(9) < 7);
            core_ready = ($urandom_range(9) < 6);
            clear      = ($urandom_range(99) < 3);
            in_data    = $urandom;
            cycle();
        end
        clear = 1'b0; in_valid = 1'b0; core_ready = 1'b1;
        cycle(); cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
